exc_entry_ctrl: RTL and testbench

Exception entry/return sequencer for the ARM-style core. It arbitrates pending exception requests and owns the current mode `M`, I bit and F bit. It drives the banked register file's write port in a fixed order: switch mode, then write the new mode's banked r14, then write PC with the vector. On exception return it restores mode and mask bits from a supplied SPSR value and reloads PC.

---
 rtl/cpu_pkg.sv | 91 +++++++++
 rtl/exc_entry_ctrl_if.sv | 35 +++
 rtl/exc_prio_enc.sv | 41 ++++
 rtl/exc_entry_ctrl.sv | 178 +++++++++++++++++
 tb/tb_exc_entry_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the exception entry/return sequencer: processor modes,
// exception indices, vector/LR offsets and the sequencer state enum.
package cpu_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  localparam int NUM_EXC = 6;

  localparam logic [31:0] VEC_OFF_UND  = 32'h0000_0004;
  localparam logic [31:0] VEC_OFF_SVC  = 32'h0000_0008;
  localparam logic [31:0] VEC_OFF_PABT = 32'h0000_000C;
  localparam logic [31:0] VEC_OFF_DABT = 32'h0000_0010;
  localparam logic [31:0] VEC_OFF_IRQ  = 32'h0000_0018;
  localparam logic [31:0] VEC_OFF_FIQ  = 32'h0000_001C;

  localparam logic [31:0] LR_OFF_UND  = 32'd0;
  localparam logic [31:0] LR_OFF_SVC  = 32'd0;
  localparam logic [31:0] LR_OFF_PABT = 32'd4;
  localparam logic [31:0] LR_OFF_DABT = 32'd8;
  localparam logic [31:0] LR_OFF_IRQ  = 32'd4;
  localparam logic [31:0] LR_OFF_FIQ  = 32'd4;

  // Values match the bit positions of exc_req / exc_ack.
  typedef enum logic [2:0] {
    EXC_UND  = 3'd0,
    EXC_SVC  = 3'd1,
    EXC_PABT = 3'd2,
    EXC_DABT = 3'd3,
    EXC_IRQ  = 3'd4,
    EXC_FIQ  = 3'd5
  } exc_idx_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_WR_LR,
    ST_WR_PC,
    ST_RET
  } state_e;

  // Rank 0 is the highest priority.
  function automatic exc_idx_e prio_at(input int rank);
    case (rank)
      0:       prio_at = EXC_DABT;
      1:       prio_at = EXC_FIQ;
      2:       prio_at = EXC_IRQ;
      3:       prio_at = EXC_PABT;
      4:       prio_at = EXC_UND;
      default: prio_at = EXC_SVC;
    endcase
  endfunction

  function automatic logic [4:0] exc_mode(input exc_idx_e idx);
    case (idx)
      EXC_UND:  exc_mode = MODE_UND;
      EXC_SVC:  exc_mode = MODE_SVC;
      EXC_PABT: exc_mode = MODE_ABT;
      EXC_DABT: exc_mode = MODE_ABT;
      EXC_IRQ:  exc_mode = MODE_IRQ;
      default:  exc_mode = MODE_FIQ;
    endcase
  endfunction

  function automatic logic [31:0] exc_vec_off(input exc_idx_e idx);
    case (idx)
      EXC_UND:  exc_vec_off = VEC_OFF_UND;
      EXC_SVC:  exc_vec_off = VEC_OFF_SVC;
      EXC_PABT: exc_vec_off = VEC_OFF_PABT;
      EXC_DABT: exc_vec_off = VEC_OFF_DABT;
      EXC_IRQ:  exc_vec_off = VEC_OFF_IRQ;
      default:  exc_vec_off = VEC_OFF_FIQ;
    endcase
  endfunction

  function automatic logic [31:0] exc_lr_off(input exc_idx_e idx);
    case (idx)
      EXC_UND:  exc_lr_off = LR_OFF_UND;
      EXC_SVC:  exc_lr_off = LR_OFF_SVC;
      EXC_PABT: exc_lr_off = LR_OFF_PABT;
      EXC_DABT: exc_lr_off = LR_OFF_DABT;
      EXC_IRQ:  exc_lr_off = LR_OFF_IRQ;
      default:  exc_lr_off = LR_OFF_FIQ;
    endcase
  endfunction

endpackage

// File: rtl/exc_entry_ctrl_if.sv
// Bundle between the core pipeline/register file (master) and the exception
// sequencer (slave).
interface exc_entry_ctrl_if;
  logic [5:0]  exc_req;
  logic [31:0] ret_pc;
  logic        eret_req;
  logic [31:0] eret_pc;
  logic [31:0] spsr_in;

  logic [4:0]  M;
  logic        write_reg;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        write_pc;
  logic [31:0] pc_data;
  logic        spsr_we;
  logic [31:0] spsr_data;
  logic        i_bit;
  logic        f_bit;
  logic        busy;
  logic [5:0]  exc_ack;
  logic        eret_ack;

  modport master (
    output exc_req, ret_pc, eret_req, eret_pc, spsr_in,
    input  M, write_reg, w_addr, w_data, write_pc, pc_data, spsr_we,
           spsr_data, i_bit, f_bit, busy, exc_ack, eret_ack
  );

  modport slave (
    input  exc_req, ret_pc, eret_req, eret_pc, spsr_in,
    output M, write_reg, w_addr, w_data, write_pc, pc_data, spsr_we,
           spsr_data, i_bit, f_bit, busy, exc_ack, eret_ack
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Masked priority encoder: irq/fiq gated by their mask bits, then the highest
// ranked remaining request is returned one-hot.
module exc_prio_enc
  import cpu_pkg::*;
(
  input  logic [5:0] exc_req,
  input  logic       i_mask,
  input  logic       f_mask,
  output logic [5:0] sel_oh,
  output logic       valid
);

  logic [5:0] masked;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_EXC; gi++) begin : g_mask
      if (gi == int'(EXC_IRQ)) begin : g_irq
        assign masked[gi] = exc_req[gi] & ~i_mask;
      end else if (gi == int'(EXC_FIQ)) begin : g_fiq
        assign masked[gi] = exc_req[gi] & ~f_mask;
      end else begin : g_plain
        assign masked[gi] = exc_req[gi];
      end
    end
  endgenerate

  // Walk from lowest to highest rank so the highest-ranked hit is written last.
  always_comb begin
    sel_oh = '0;
    for (int k = NUM_EXC - 1; k >= 0; k--) begin
      if (masked[prio_at(k)]) begin
        sel_oh = '0;
        sel_oh[prio_at(k)] = 1'b1;
      end
    end
  end

  assign valid = |masked;

endmodule

// File: rtl/exc_entry_ctrl.sv
// Exception entry/return sequencer: owns mode and I/F masks, sequences
// mode switch -> banked r14 write -> PC vector write, and SPSR-driven return.
module exc_entry_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  exc_entry_ctrl_if.slave  bus
);

  state_e      state_reg, state_next;
  exc_idx_e    exc_sel_reg, exc_sel_next;
  logic [5:0]  exc_oh_reg, exc_oh_next;

  logic [4:0]  m_reg, m_next;
  logic        i_reg, i_next;
  logic        f_reg, f_next;
  logic        spsr_we_reg, spsr_we_next;
  logic [31:0] spsr_data_reg, spsr_data_next;
  logic        write_reg_reg, write_reg_next;
  logic [3:0]  w_addr_reg, w_addr_next;
  logic [31:0] w_data_reg, w_data_next;
  logic        write_pc_reg, write_pc_next;
  logic [31:0] pc_data_reg, pc_data_next;
  logic [5:0]  exc_ack_reg, exc_ack_next;
  logic        eret_ack_reg, eret_ack_next;
  logic        busy_reg, busy_next;

  logic [5:0]  prio_oh;
  logic        prio_valid;
  exc_idx_e    prio_idx;

  exc_prio_enc u_prio (
    .exc_req (bus.exc_req),
    .i_mask  (i_reg),
    .f_mask  (f_reg),
    .sel_oh  (prio_oh),
    .valid   (prio_valid)
  );

  always_comb begin
    prio_idx = EXC_UND;
    for (int k = 0; k < NUM_EXC; k++) begin
      if (prio_oh[k]) begin
        prio_idx = exc_idx_e'(3'(k));
      end
    end
  end

  // Only I/F and the mode field of the SPSR participate in a return.
  logic unused_spsr;
  assign unused_spsr = ^{bus.spsr_in[31:8], bus.spsr_in[5]};

  always_comb begin
    state_next     = state_reg;
    exc_sel_next   = exc_sel_reg;
    exc_oh_next    = exc_oh_reg;
    m_next         = m_reg;
    i_next         = i_reg;
    f_next         = f_reg;
    spsr_we_next   = 1'b0;
    spsr_data_next = spsr_data_reg;
    write_reg_next = 1'b0;
    w_addr_next    = w_addr_reg;
    w_data_next    = w_data_reg;
    write_pc_next  = 1'b0;
    pc_data_next   = pc_data_reg;
    exc_ack_next   = '0;
    eret_ack_next  = 1'b0;
    busy_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (prio_valid) begin
          state_next   = ST_SWITCH;
          exc_sel_next = prio_idx;
          exc_oh_next  = prio_oh;
        end else if (bus.eret_req) begin
          state_next = ST_RET;
        end
      end
      ST_SWITCH: begin
        busy_next      = 1'b1;
        m_next         = exc_mode(exc_sel_reg);
        spsr_we_next   = 1'b1;
        spsr_data_next = {24'b0, i_reg, f_reg, 1'b0, m_reg};
        i_next         = 1'b1;
        if (exc_sel_reg == EXC_FIQ) begin
          f_next = 1'b1;
        end
        state_next     = ST_WR_LR;
      end
      ST_WR_LR: begin
        // M already holds the new mode, so r14 resolves to the banked copy.
        busy_next      = 1'b1;
        write_reg_next = 1'b1;
        w_addr_next    = 4'd14;
        w_data_next    = bus.ret_pc + exc_lr_off(exc_sel_reg);
        state_next     = ST_WR_PC;
      end
      ST_WR_PC: begin
        busy_next     = 1'b1;
        write_pc_next = 1'b1;
        pc_data_next  = VEC_BASE + exc_vec_off(exc_sel_reg);
        exc_ack_next  = exc_oh_reg;
        state_next    = ST_IDLE;
      end
      ST_RET: begin
        busy_next     = 1'b1;
        m_next        = bus.spsr_in[4] ? bus.spsr_in[4:0] : MODE_SVC;
        i_next        = bus.spsr_in[7];
        f_next        = bus.spsr_in[6];
        write_pc_next = 1'b1;
        pc_data_next  = bus.eret_pc;
        eret_ack_next = 1'b1;
        state_next    = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      exc_sel_reg   <= EXC_UND;
      exc_oh_reg    <= '0;
      m_reg         <= MODE_SVC;
      i_reg         <= 1'b1;
      f_reg         <= 1'b1;
      spsr_we_reg   <= 1'b0;
      spsr_data_reg <= '0;
      write_reg_reg <= 1'b0;
      w_addr_reg    <= '0;
      w_data_reg    <= '0;
      write_pc_reg  <= 1'b0;
      pc_data_reg   <= '0;
      exc_ack_reg   <= '0;
      eret_ack_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      exc_sel_reg   <= exc_sel_next;
      exc_oh_reg    <= exc_oh_next;
      m_reg         <= m_next;
      i_reg         <= i_next;
      f_reg         <= f_next;
      spsr_we_reg   <= spsr_we_next;
      spsr_data_reg <= spsr_data_next;
      write_reg_reg <= write_reg_next;
      w_addr_reg    <= w_addr_next;
      w_data_reg    <= w_data_next;
      write_pc_reg  <= write_pc_next;
      pc_data_reg   <= pc_data_next;
      exc_ack_reg   <= exc_ack_next;
      eret_ack_reg  <= eret_ack_next;
      busy_reg      <= busy_next;
    end
  end

  assign bus.M         = m_reg;
  assign bus.i_bit     = i_reg;
  assign bus.f_bit     = f_reg;
  assign bus.spsr_we   = spsr_we_reg;
  assign bus.spsr_data = spsr_data_reg;
  assign bus.write_reg = write_reg_reg;
  assign bus.w_addr    = w_addr_reg;
  assign bus.w_data    = w_data_reg;
  assign bus.write_pc  = write_pc_reg;
  assign bus.pc_data   = pc_data_reg;
  assign bus.exc_ack   = exc_ack_reg;
  assign bus.eret_ack  = eret_ack_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Directed bench for exc_entry_ctrl: entry sequences, masking, priority,
// returns (legal and illegal mode), wrap-around and asynchronous reset.
module tb_exc_entry_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  exc_entry_ctrl_if bus ();

  exc_entry_ctrl #(.VEC_BASE(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  m;
    logic        i;
    logic        f;
    logic        spsr_we;
    logic [31:0] spsr_data;
    logic        write_reg;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        write_pc;
    logic [31:0] pc_data;
    logic [5:0]  exc_ack;
    logic        eret_ack;
    logic        busy;
  } snap_t;

  snap_t sw, lr, pc, post, rt, rt_post;

  function automatic snap_t cap();
    snap_t s;
    s.m = bus.M;             s.i = bus.i_bit;          s.f = bus.f_bit;
    s.spsr_we = bus.spsr_we; s.spsr_data = bus.spsr_data;
    s.write_reg = bus.write_reg; s.w_addr = bus.w_addr; s.w_data = bus.w_data;
    s.write_pc = bus.write_pc;   s.pc_data = bus.pc_data;
    s.exc_ack = bus.exc_ack; s.eret_ack = bus.eret_ack; s.busy = bus.busy;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents req for one sampling edge, then leaves 'hold' on exc_req and
  // records the outputs after each of the four following edges.
  task automatic do_entry(input logic [5:0] req, input logic [5:0] hold,
                          input logic [31:0] rpc);
    bus.exc_req = req;
    bus.ret_pc  = rpc;
    step();
    bus.exc_req  = hold;
    bus.eret_req = 1'b0;
    step(); sw   = cap();
    step(); lr   = cap();
    step(); pc   = cap();
    step(); post = cap();
  endtask

  task automatic do_eret(input logic [31:0] spsr, input logic [31:0] epc);
    bus.spsr_in  = spsr;
    bus.eret_pc  = epc;
    bus.eret_req = 1'b1;
    step();
    bus.eret_req = 1'b0;
    step(); rt      = cap();
    step(); rt_post = cap();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.exc_req = '0; bus.ret_pc = '0; bus.eret_req = 1'b0;
    bus.eret_pc = '0; bus.spsr_in = '0;
    #12;
    checks++; if (bus.M !== 5'b10011) begin errors++; $display("FAIL reset_M: got %b exp %b", bus.M, 5'b10011); end
    checks++; if ({bus.i_bit, bus.f_bit} !== 2'b11) begin errors++; $display("FAIL reset_IF: got %b exp 11", {bus.i_bit, bus.f_bit}); end
    checks++; if ({bus.spsr_we, bus.write_reg, bus.write_pc, bus.eret_ack, bus.busy} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b exp 00000", {bus.spsr_we, bus.write_reg, bus.write_pc, bus.eret_ack, bus.busy}); end
    checks++; if (bus.exc_ack !== 6'b0) begin errors++; $display("FAIL reset_exc_ack: got %b exp 000000", bus.exc_ack); end
    checks++; if ({bus.w_addr, bus.w_data, bus.pc_data, bus.spsr_data} !== 100'b0) begin errors++; $display("FAIL reset_data: w_addr %h w_data %h pc %h spsr %h exp all 0", bus.w_addr, bus.w_data, bus.pc_data, bus.spsr_data); end
    @(negedge clk); rst = 1'b0;
    step();
    $display("reset: M=%b I=%b F=%b", bus.M, bus.i_bit, bus.f_bit);
  endtask

  task automatic test_irq_masked();
    bus.exc_req = 6'b010000;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (bus.busy !== 1'b0 || bus.exc_ack !== 6'b0) begin errors++; $display("FAIL irq_masked_c%0d: busy %b ack %b exp 0 000000", c, bus.busy, bus.exc_ack); end
    end
    bus.exc_req = '0;
    $display("irq with I=1: busy=%b", bus.busy);
  endtask

  task automatic test_eret_unmask();
    do_eret(32'h0000_0013, 32'h0000_3000);
    checks++; if (rt.m !== 5'b10011 || rt.i !== 1'b0 || rt.f !== 1'b0) begin errors++; $display("FAIL eret_unmask_mif: got %b %b %b exp 10011 0 0", rt.m, rt.i, rt.f); end
    checks++; if (rt.pc_data !== 32'h3000 || rt.write_pc !== 1'b1) begin errors++; $display("FAIL eret_unmask_pc: got %h we %b exp 00003000 1", rt.pc_data, rt.write_pc); end
    $display("eret spsr=13 pc=%h", rt.pc_data);
  endtask

  task automatic test_irq_entry();
    do_entry(6'b010000, 6'b000000, 32'h0000_0100);
    checks++; if (sw.m !== 5'b10010) begin errors++; $display("FAIL irq_sw_M: got %b exp 10010", sw.m); end
    checks++; if (sw.spsr_we !== 1'b1 || sw.spsr_data !== 32'h0000_0013) begin errors++; $display("FAIL irq_sw_spsr: we %b data %h exp 1 00000013", sw.spsr_we, sw.spsr_data); end
    checks++; if (sw.i !== 1'b1 || sw.f !== 1'b0 || sw.busy !== 1'b1 || sw.write_reg !== 1'b0) begin errors++; $display("FAIL irq_sw_flags: I %b F %b busy %b wr %b exp 1 0 1 0", sw.i, sw.f, sw.busy, sw.write_reg); end
    checks++; if (lr.write_reg !== 1'b1 || lr.w_addr !== 4'd14 || lr.w_data !== 32'h104) begin errors++; $display("FAIL irq_lr: we %b addr %0d data %h exp 1 14 00000104", lr.write_reg, lr.w_addr, lr.w_data); end
    checks++; if (lr.spsr_we !== 1'b0 || lr.write_pc !== 1'b0 || lr.exc_ack !== 6'b0) begin errors++; $display("FAIL irq_lr_strobes: spsr_we %b wpc %b ack %b exp 0 0 0", lr.spsr_we, lr.write_pc, lr.exc_ack); end
    checks++; if (pc.write_pc !== 1'b1 || pc.pc_data !== 32'h18 || pc.exc_ack !== 6'b010000) begin errors++; $display("FAIL irq_pc: we %b pc %h ack %b exp 1 00000018 010000", pc.write_pc, pc.pc_data, pc.exc_ack); end
    checks++; if (pc.write_reg !== 1'b0 || pc.busy !== 1'b1) begin errors++; $display("FAIL irq_pc_flags: wr %b busy %b exp 0 1", pc.write_reg, pc.busy); end
    checks++; if (post.busy !== 1'b0 || post.write_pc !== 1'b0 || post.exc_ack !== 6'b0) begin errors++; $display("FAIL irq_done: busy %b wpc %b ack %b exp 0 0 0", post.busy, post.write_pc, post.exc_ack); end
    $display("irq entry: lr=%h pc=%h ack=%b", lr.w_data, pc.pc_data, pc.exc_ack);
  endtask

  task automatic test_eret();
    do_eret(32'h0000_0010, 32'h0000_2000);
    checks++; if (rt.m !== 5'b10000 || rt.i !== 1'b0 || rt.f !== 1'b0) begin errors++; $display("FAIL eret_mif: got %b %b %b exp 10000 0 0", rt.m, rt.i, rt.f); end
    checks++; if (rt.write_pc !== 1'b1 || rt.pc_data !== 32'h2000 || rt.eret_ack !== 1'b1 || rt.busy !== 1'b1) begin errors++; $display("FAIL eret_pc: we %b pc %h ack %b busy %b exp 1 00002000 1 1", rt.write_pc, rt.pc_data, rt.eret_ack, rt.busy); end
    checks++; if (rt_post.write_pc !== 1'b0 || rt_post.eret_ack !== 1'b0 || rt_post.busy !== 1'b0) begin errors++; $display("FAIL eret_done: wpc %b ack %b busy %b exp 0 0 0", rt_post.write_pc, rt_post.eret_ack, rt_post.busy); end
    $display("eret spsr=10 pc=%h M=%b", rt.pc_data, rt.m);
  endtask

  task automatic test_dabt_over_irq();
    do_entry(6'b011000, 6'b010000, 32'h0000_0200);
    checks++; if (sw.m !== 5'b10111 || sw.spsr_data !== 32'h0000_0010 || sw.i !== 1'b1) begin errors++; $display("FAIL dabt_sw: M %b spsr %h I %b exp 10111 00000010 1", sw.m, sw.spsr_data, sw.i); end
    checks++; if (lr.w_data !== 32'h208) begin errors++; $display("FAIL dabt_lr: got %h exp 00000208", lr.w_data); end
    checks++; if (pc.pc_data !== 32'h10 || pc.exc_ack !== 6'b001000) begin errors++; $display("FAIL dabt_pc: pc %h ack %b exp 00000010 001000", pc.pc_data, pc.exc_ack); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.busy !== 1'b0 || bus.exc_ack !== 6'b0) begin errors++; $display("FAIL dabt_irq_held_c%0d: busy %b ack %b exp 0 000000", c, bus.busy, bus.exc_ack); end
      step();
    end
    bus.exc_req = '0;
    $display("dabt+irq: ack=%b, irq left pending under I=1", pc.exc_ack);
  endtask

  task automatic test_wrap();
    do_entry(6'b001000, 6'b000000, 32'hFFFF_FFFC);
    checks++; if (sw.spsr_data !== 32'h0000_0097) begin errors++; $display("FAIL wrap_spsr: got %h exp 00000097", sw.spsr_data); end
    checks++; if (lr.w_data !== 32'h0000_0004) begin errors++; $display("FAIL wrap_lr: got %h exp 00000004", lr.w_data); end
    $display("dabt wrap: lr=%h", lr.w_data);
  endtask

  task automatic test_illegal_eret();
    do_eret(32'h0000_00C3, 32'h0000_0040);
    checks++; if (rt.m !== 5'b10011 || rt.i !== 1'b1 || rt.f !== 1'b1) begin errors++; $display("FAIL illegal_eret_mif: got %b %b %b exp 10011 1 1", rt.m, rt.i, rt.f); end
    checks++; if (rt.write_pc !== 1'b1 || rt.pc_data !== 32'h40 || rt.eret_ack !== 1'b1) begin errors++; $display("FAIL illegal_eret_pc: we %b pc %h ack %b exp 1 00000040 1", rt.write_pc, rt.pc_data, rt.eret_ack); end
    $display("eret illegal mode: M=%b pc=%h", rt.m, rt.pc_data);
  endtask

  task automatic test_fiq_over_irq();
    do_eret(32'h0000_0010, 32'h0000_0500);
    do_entry(6'b110000, 6'b000000, 32'h0000_0300);
    checks++; if (sw.m !== 5'b10001 || sw.spsr_data !== 32'h0000_0010 || sw.i !== 1'b1 || sw.f !== 1'b1) begin errors++; $display("FAIL fiq_sw: M %b spsr %h I %b F %b exp 10001 00000010 1 1", sw.m, sw.spsr_data, sw.i, sw.f); end
    checks++; if (lr.w_data !== 32'h304) begin errors++; $display("FAIL fiq_lr: got %h exp 00000304", lr.w_data); end
    checks++; if (pc.pc_data !== 32'h1C || pc.exc_ack !== 6'b100000) begin errors++; $display("FAIL fiq_pc: pc %h ack %b exp 0000001c 100000", pc.pc_data, pc.exc_ack); end
    $display("fiq+irq: ack=%b pc=%h", pc.exc_ack, pc.pc_data);
  endtask

  task automatic test_exc_over_eret();
    bus.spsr_in  = 32'h0000_0010;
    bus.eret_req = 1'b1;
    do_entry(6'b000010, 6'b000000, 32'h0000_0400);
    checks++; if (sw.m !== 5'b10011 || sw.spsr_data !== 32'h0000_00D1 || sw.eret_ack !== 1'b0) begin errors++; $display("FAIL svc_eret_sw: M %b spsr %h eret_ack %b exp 10011 000000d1 0", sw.m, sw.spsr_data, sw.eret_ack); end
    checks++; if (lr.w_data !== 32'h400 || pc.pc_data !== 32'h08 || pc.exc_ack !== 6'b000010) begin errors++; $display("FAIL svc_eret_seq: lr %h pc %h ack %b exp 00000400 00000008 000010", lr.w_data, pc.pc_data, pc.exc_ack); end
    checks++; if (post.eret_ack !== 1'b0 || post.busy !== 1'b0) begin errors++; $display("FAIL svc_eret_done: eret_ack %b busy %b exp 0 0", post.eret_ack, post.busy); end
    $display("svc vs eret: ack=%b", pc.exc_ack);
  endtask

  task automatic test_reset_mid();
    logic saw_wpc;
    saw_wpc = 1'b0;
    bus.exc_req = 6'b000010;
    bus.ret_pc  = 32'h0000_0600;
    step();
    bus.exc_req = '0;
    step();
    step();
    checks++; if (bus.write_reg !== 1'b1 || bus.w_data !== 32'h600) begin errors++; $display("FAIL rstmid_lr: wr %b data %h exp 1 00000600", bus.write_reg, bus.w_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.M !== 5'b10011 || bus.i_bit !== 1'b1 || bus.f_bit !== 1'b1) begin errors++; $display("FAIL rstmid_mode: M %b I %b F %b exp 10011 1 1", bus.M, bus.i_bit, bus.f_bit); end
    checks++; if ({bus.spsr_we, bus.write_reg, bus.write_pc, bus.busy} !== 4'b0 || bus.exc_ack !== 6'b0) begin errors++; $display("FAIL rstmid_strobes: %b ack %b exp 0000 000000", {bus.spsr_we, bus.write_reg, bus.write_pc, bus.busy}, bus.exc_ack); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.write_pc !== 1'b0 || bus.busy !== 1'b0) saw_wpc = 1'b1;
    end
    checks++; if (saw_wpc !== 1'b0) begin errors++; $display("FAIL rstmid_no_pc: activity %b exp 0", saw_wpc); end
    $display("reset during WR_LR: M=%b busy=%b", bus.M, bus.busy);
  endtask

  initial begin
    test_reset();
    test_irq_masked();
    test_eret_unmask();
    test_irq_entry();
    test_eret();
    test_dabt_over_irq();
    test_wrap();
    test_illegal_eret();
    test_fiq_over_irq();
    test_exc_over_eret();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
